fifo_ptr_ctrl: RTL and testbench



---
 rtl/fifo_ptr_ctrl_if.sv | 35 +++
 rtl/fifo_ptr_ctrl.sv | 115 +++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ptr_ctrl_if.sv
// Bus between the FIFO pointer control stage and its producer, consumer and pointer counters.
// Handshake: wr_req/rd_req are requests held by the requester; wr_en/rd_en are same-cycle
// grants, and a transfer happens on a rising edge only where request and grant are both high.
interface fifo_ptr_ctrl_if #(
    parameter int AW = 4
);
    logic [31:0] wr_ptr_grey;
    logic [31:0] rd_ptr_grey;
    logic        wr_req;
    logic        rd_req;
    logic        flush;
    logic        wr_en;
    logic        rd_en;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [AW:0] count;
    logic        flush_busy;
    logic        flush_done;
    logic        ptr_err;
    logic [1:0]  fsm_state;

    modport master (
        output wr_ptr_grey, rd_ptr_grey, wr_req, rd_req, flush,
        input  wr_en, rd_en, full, empty, almost_full, almost_empty,
        input  count, flush_busy, flush_done, ptr_err, fsm_state
    );

    modport slave (
        input  wr_ptr_grey, rd_ptr_grey, wr_req, rd_req, flush,
        output wr_en, rd_en, full, empty, almost_full, almost_empty,
        output count, flush_busy, flush_done, ptr_err, fsm_state
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer control: grey pointer decode, occupancy flags, counter enable gating,
// flush drain sequencing and sticky pointer integrity checking.
module fifo_ptr_ctrl #(
    parameter int AW        = 4,
    parameter int AFULL_TH  = (1 << AW) - 2,
    parameter int AEMPTY_TH = 2
) (
    input logic           clk,
    input logic           rst,
    fifo_ptr_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] DEPTH_V  = DEPTH[AW:0];
    localparam logic [AW:0] AFULL_V  = AFULL_TH[AW:0];
    localparam logic [AW:0] AEMPTY_V = AEMPTY_TH[AW:0];

    // Bit i of the binary value is the XOR of grey bits 31..i, so every grey bit matters.
    function automatic logic [AW:0] grey_low_bits(input logic [31:0] g);
        logic [AW:0] b;
        for (int i = 0; i <= AW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [AW:0] wbin;
    logic [AW:0] rbin;
    logic [AW:0] occ;
    logic [31:0] prev_wr;
    logic [31:0] prev_rd;
    logic [31:0] wr_delta;
    logic [31:0] rd_delta;
    logic        bad_step;
    logic        over_fill;
    logic        full_c;
    logic        empty_c;
    logic        wr_grant;
    logic        rd_grant;
    logic        done_c;
    logic [AW:0] count_q;
    logic        ptr_err_q;

    assign wbin    = grey_low_bits(bus.wr_ptr_grey);
    assign rbin    = grey_low_bits(bus.rd_ptr_grey);
    assign occ     = wbin - rbin;
    assign full_c  = (occ == DEPTH_V);
    assign empty_c = (occ == '0);

    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (occ >= AFULL_V);
    assign bus.almost_empty = (occ <= AEMPTY_V);

    // A legal grey step flips exactly zero or one bit; x & (x-1) is non-zero for two or more.
    assign wr_delta  = bus.wr_ptr_grey ^ prev_wr;
    assign rd_delta  = bus.rd_ptr_grey ^ prev_rd;
    assign bad_step  = (|(wr_delta & (wr_delta - 32'd1))) | (|(rd_delta & (rd_delta - 32'd1)));
    assign over_fill = (occ > DEPTH_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count_q   <= '0;
            ptr_err_q <= 1'b0;
            prev_wr   <= '0;
            prev_rd   <= '0;
        end else begin
            state     <= state_nxt;
            count_q   <= occ;
            ptr_err_q <= ptr_err_q | bad_step | over_fill;
            prev_wr   <= bus.wr_ptr_grey;
            prev_rd   <= bus.rd_ptr_grey;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_grant  = 1'b0;
        rd_grant  = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                wr_grant = bus.wr_req & ~full_c;
                rd_grant = bus.rd_req & ~empty_c;
                if (bus.flush) state_nxt = DRAIN;
            end
            DRAIN: begin
                rd_grant = ~empty_c;
                if (empty_c) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters must not move while the whole FIFO is being reset.
    assign bus.wr_en      = wr_grant & ~rst;
    assign bus.rd_en      = rd_grant & ~rst;
    assign bus.flush_done = done_c & ~rst;
    assign bus.flush_busy = (state != IDLE);
    assign bus.count      = count_q;
    assign bus.ptr_err    = ptr_err_q;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl with behavioural write/read pointer counters.
module tb_fifo_ptr_ctrl;
    localparam int AW = 4;

    logic        clk;
    logic        rst;
    logic [31:0] wr_bin;
    logic [31:0] rd_bin;
    logic        wr_ovr;
    logic [31:0] wr_ovr_val;
    int          checks;
    int          errors;
    int          wr_pulses;

    fifo_ptr_ctrl_if #(.AW(AW)) bus ();

    fifo_ptr_ctrl #(.AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pointer counters driven by the grants, like the real grey counters
    always @(posedge clk) begin
        if (rst) begin
            wr_bin <= '0;
            rd_bin <= '0;
        end else begin
            if (bus.wr_en) wr_bin <= wr_bin + 32'd1;
            if (bus.rd_en) rd_bin <= rd_bin + 32'd1;
        end
    end

    assign bus.wr_ptr_grey = wr_ovr ? wr_ovr_val : (wr_bin ^ (wr_bin >> 1));
    assign bus.rd_ptr_grey = rd_bin ^ (rd_bin >> 1);

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        wr_pulses  = 0;
        wr_ovr     = 1'b0;
        wr_ovr_val = '0;
        rst        = 1'b1;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        bus.flush  = 1'b0;

        // reset, with both requests high
        tick();
        tick();
        #1;
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_aempty", 32'(bus.almost_empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_ptr_err", 32'(bus.ptr_err), 32'd0);
        chk("rst_busy", 32'(bus.flush_busy), 32'd0);
        chk("rst_state", 32'(bus.fsm_state), 32'd0);
        rst        = 1'b0;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        tick();

        // fill: 20 cycles of write requests, exactly 16 grants
        bus.wr_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.wr_en) wr_pulses++;
            if (i == 13) chk("fill_afull_13", 32'(bus.almost_full), 32'd0);
            if (i == 14) chk("fill_afull_14", 32'(bus.almost_full), 32'd1);
            if (i == 15) chk("fill_full_15", 32'(bus.full), 32'd0);
            if (i == 16) begin
                chk("fill_full_16", 32'(bus.full), 32'd1);
                chk("fill_count_lag", 32'(bus.count), 32'd15);
            end
            if (i == 17) chk("fill_count_16", 32'(bus.count), 32'd16);
            tick();
        end
        chk("fill_pulses", 32'(wr_pulses), 32'd16);
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_count", 32'(bus.count), 32'd16);
        bus.rd_req = 1'b1;
        #1;
        chk("full_rw_rd_en", 32'(bus.rd_en), 32'd1);
        chk("full_rw_wr_en", 32'(bus.wr_en), 32'd0);
        tick();
        bus.rd_req = 1'b0;
        #1;
        chk("occ15_wr_en", 32'(bus.wr_en), 32'd1);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b1;
        repeat (15) tick();
        #1;
        chk("drained_empty", 32'(bus.empty), 32'd1);
        chk("drained_rd_en", 32'(bus.rd_en), 32'd0);
        bus.rd_req = 1'b0;

        // flush with 5 entries
        bus.wr_req = 1'b1;
        repeat (5) tick();
        bus.wr_req = 1'b0;
        bus.flush  = 1'b1;
        tick();
        bus.flush  = 1'b0;
        bus.wr_req = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            #1;
            chk($sformatf("fl5_rd_en_%0d", j), 32'(bus.rd_en), (j <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("fl5_wr_en_%0d", j), 32'(bus.wr_en), 32'd0);
            chk($sformatf("fl5_busy_%0d", j), 32'(bus.flush_busy), 32'd1);
            chk($sformatf("fl5_done_%0d", j), 32'(bus.flush_done), (j == 7) ? 32'd1 : 32'd0);
            tick();
        end
        bus.wr_req = 1'b0;
        #1;
        chk("fl5_busy_after", 32'(bus.flush_busy), 32'd0);
        chk("fl5_done_after", 32'(bus.flush_done), 32'd0);

        // flush of an empty FIFO
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl0_busy_t1", 32'(bus.flush_busy), 32'd1);
        chk("fl0_done_t1", 32'(bus.flush_done), 32'd0);
        tick();
        chk("fl0_done_t2", 32'(bus.flush_done), 32'd1);
        tick();
        chk("fl0_busy_t3", 32'(bus.flush_busy), 32'd0);
        chk("fl0_done_t3", 32'(bus.flush_done), 32'd0);

        // wrap: steady occupancy of 3 while streaming 100 transfers
        bus.wr_req = 1'b1;
        repeat (3) tick();
        bus.rd_req = 1'b1;
        repeat (100) tick();
        chk("wrap_count", 32'(bus.count), 32'd3);
        chk("wrap_aempty", 32'(bus.almost_empty), 32'd0);
        chk("wrap_ptr_err", 32'(bus.ptr_err), 32'd0);
        chk("wrap_wr_bin", wr_bin, 32'd124);
        bus.wr_req = 1'b0;
        repeat (3) tick();
        chk("wrap_empty", 32'(bus.empty), 32'd1);
        bus.rd_req = 1'b0;

        // reset in the middle of a drain
        bus.wr_req = 1'b1;
        repeat (4) tick();
        bus.wr_req = 1'b0;
        bus.flush  = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("mid_state_drain", 32'(bus.fsm_state), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_en", 32'(bus.rd_en), 32'd0);
        tick();
        chk("mid_state_idle", 32'(bus.fsm_state), 32'd0);
        chk("mid_busy", 32'(bus.flush_busy), 32'd0);
        chk("mid_done", 32'(bus.flush_done), 32'd0);
        chk("mid_count", 32'(bus.count), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mid_no_done_%0d", k), 32'(bus.flush_done), 32'd0);
            tick();
        end

        // integrity: two-bit jump on the write pointer
        wr_ovr     = 1'b1;
        wr_ovr_val = 32'h1;
        tick();
        chk("jump_ok_step", 32'(bus.ptr_err), 32'd0);
        wr_ovr_val = 32'h2;
        #1;
        chk("jump_not_yet", 32'(bus.ptr_err), 32'd0);
        tick();
        chk("jump_err", 32'(bus.ptr_err), 32'd1);
        repeat (3) tick();
        chk("jump_sticky", 32'(bus.ptr_err), 32'd1);
        wr_ovr = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        chk("jump_cleared", 32'(bus.ptr_err), 32'd0);
        tick();
        chk("jump_stays_clear", 32'(bus.ptr_err), 32'd0);

        // integrity: walk the write pointer one grey step at a time to occupancy 17
        wr_ovr     = 1'b1;
        wr_ovr_val = 32'h0;
        for (int i = 1; i <= 16; i++) begin
            wr_ovr_val = 32'(i) ^ (32'(i) >> 1);
            tick();
        end
        chk("occ16_full", 32'(bus.full), 32'd1);
        chk("occ16_count", 32'(bus.count), 32'd16);
        chk("occ16_ptr_err", 32'(bus.ptr_err), 32'd0);
        wr_ovr_val = 32'h19;
        #1;
        chk("occ17_full", 32'(bus.full), 32'd0);
        chk("occ17_not_yet", 32'(bus.ptr_err), 32'd0);
        tick();
        chk("occ17_err", 32'(bus.ptr_err), 32'd1);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
